// File: rtl/shift_register.sv
// Parallel-out shift register with serial LSB-first loading and an
// arithmetic (sign-replicating) right shift that takes priority over the serial shift.
module shift_register #(
  parameter int x = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         shift_en,
  input  logic         shift_in,
  input  logic         extend,
  output logic [x-1:0] q
);

  // Priority is reset, then arithmetic shift, then serial shift, otherwise hold.
  // The serial input is ignored whenever extend is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (extend) begin
      q <= {q[x-1], q[x-1:1]};
    end else if (shift_en) begin
      q <= {shift_in, q[x-1:1]};
    end
  end

endmodule

// File: tb/tb_shift_register.sv
// Self-checking bench for shift_register: an x=8 and an x=4 instance are checked
// against an integer reference model, using both directed and random stimulus.
module tb_shift_register;

  logic       clk;
  logic       rst, shiftEn, shiftIn, extend;
  logic [7:0] q8;
  logic       rst4, shiftEn4, shiftIn4, extend4;
  logic [3:0] q4;

  int checks = 0;
  int errors = 0;
  int model8;
  int model4;

  shift_register #(.x(8)) dut8 (
    .clk(clk), .rst(rst), .shift_en(shiftEn), .shift_in(shiftIn),
    .extend(extend), .q(q8)
  );

  shift_register #(.x(4)) dut4 (
    .clk(clk), .rst(rst4), .shift_en(shiftEn4), .shift_in(shiftIn4),
    .extend(extend4), .q(q4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference behaviour as plain arithmetic on an unsigned value of w bits.
  function automatic int refNext(int cur, int w, bit r, bit e, bit en, bit din);
    int sign;
    if (r) return 0;
    if (e) begin
      sign = (cur >> (w - 1)) & 1;
      return (cur >> 1) + sign * (1 << (w - 1));
    end
    if (en) return (cur >> 1) + int'(din) * (1 << (w - 1));
    return cur;
  endfunction

  // One clock of the x=8 instance: drive on the falling edge, then sample 1 time unit after the rising edge.
  task automatic cycle8(input bit r, input bit e, input bit en, input bit din);
    @(negedge clk);
    rst = r; extend = e; shiftEn = en; shiftIn = din;
    @(posedge clk);
    #1;
    model8 = refNext(model8, 8, r, e, en, din);
  endtask

  task automatic cycle4(input bit r, input bit e, input bit en, input bit din);
    @(negedge clk);
    rst4 = r; extend4 = e; shiftEn4 = en; shiftIn4 = din;
    @(posedge clk);
    #1;
    model4 = refNext(model4, 4, r, e, en, din);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      rst = 1'b1; extend = 1'($urandom); shiftEn = 1'($urandom); shiftIn = 1'($urandom);
      rst4 = 1'b1; extend4 = 1'($urandom); shiftEn4 = 1'($urandom); shiftIn4 = 1'($urandom);
      @(posedge clk);
      #1;
      model8 = 0;
      model4 = 0;
      checks++;
      if (q8 !== 8'h00) begin
        errors++;
        $display("[TB] FAIL reset8 edge %0d: q=%b expected=%b", i, q8, 8'h00);
      end
      checks++;
      if (q4 !== 4'h0) begin
        errors++;
        $display("[TB] FAIL reset4 edge %0d: q=%b expected=%b", i, q4, 4'h0);
      end
    end
    @(negedge clk);
    rst = 1'b0; rst4 = 1'b0; extend = 1'b0; extend4 = 1'b0; shiftEn = 1'b0; shiftEn4 = 1'b0;
  endtask

  task automatic test_shift_pattern();
    bit seq [8] = '{0, 1, 0, 1, 0, 0, 1, 1};
    cycle8(1, 0, 0, 0);
    foreach (seq[i]) cycle8(0, 0, 1, seq[i]);
    cycle8(0, 0, 0, 1);
    checks++;
    if (q8 !== 8'b11001010) begin
      errors++;
      $display("[TB] FAIL shift_pattern: q=%b expected=%b", q8, 8'b11001010);
    end
    repeat (3) cycle8(0, 0, 0, 1'($urandom));
    checks++;
    if (q8 !== 8'b11001010) begin
      errors++;
      $display("[TB] FAIL shift_hold: q=%b expected=%b", q8, 8'b11001010);
    end
  endtask

  task automatic test_extend();
    logic [7:0] expv [3] = '{8'b11100101, 8'b11110010, 8'b11111001};
    for (int i = 0; i < 3; i++) begin
      cycle8(0, 1, 0, 1'($urandom));
      checks++;
      if (q8 !== expv[i]) begin
        errors++;
        $display("[TB] FAIL extend step %0d: q=%b expected=%b", i, q8, expv[i]);
      end
    end
    cycle8(0, 0, 0, 0);
    checks++;
    if (q8 !== 8'b11111001) begin
      errors++;
      $display("[TB] FAIL extend_hold: q=%b expected=%b", q8, 8'b11111001);
    end
  endtask

  task automatic test_saturate();
    bit seq [8] = '{0, 0, 0, 0, 1, 0, 1, 0};
    cycle8(1, 0, 0, 0);
    foreach (seq[i]) cycle8(0, 0, 1, seq[i]);
    checks++;
    if (q8 !== 8'b01010000) begin
      errors++;
      $display("[TB] FAIL saturate_load: q=%b expected=%b", q8, 8'b01010000);
    end
    for (int i = 0; i < 8; i++) begin
      cycle8(0, 1, 1, 1);
      checks++;
      if (q8 !== 8'(model8)) begin
        errors++;
        $display("[TB] FAIL saturate step %0d: q=%b expected=%b", i, q8, 8'(model8));
      end
    end
    checks++;
    if (q8 !== 8'h00) begin
      errors++;
      $display("[TB] FAIL saturate_final: q=%b expected=%b", q8, 8'h00);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] pattern;
    repeat (4) cycle8(0, 0, 1, 1);
    cycle8(1, 0, 1, 1);
    checks++;
    if (q8 !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_mid: q=%b expected=%b", q8, 8'h00);
    end
    pattern = 8'($urandom);
    for (int i = 0; i < 8; i++) cycle8(0, 0, 1, pattern[i]);
    checks++;
    if (q8 !== pattern) begin
      errors++;
      $display("[TB] FAIL reset_mid_fresh: q=%b expected=%b", q8, pattern);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      cycle8(($urandom_range(0, 19) == 0), 1'($urandom), 1'($urandom), 1'($urandom));
      checks++;
      if (q8 !== 8'(model8)) begin
        errors++;
        $display("[TB] FAIL random cycle %0d: q=%b expected=%b", i, q8, 8'(model8));
      end
    end
  endtask

  task automatic test_width4();
    bit seq [4] = '{1, 0, 1, 1};
    cycle4(1, 0, 0, 0);
    foreach (seq[i]) cycle4(0, 0, 1, seq[i]);
    cycle4(0, 0, 0, 0);
    checks++;
    if (q4 !== 4'b1101) begin
      errors++;
      $display("[TB] FAIL width4_pattern: q=%b expected=%b", q4, 4'b1101);
    end
    for (int i = 0; i < 50; i++) begin
      cycle4(($urandom_range(0, 9) == 0), 1'($urandom), 1'($urandom), 1'($urandom));
      checks++;
      if (q4 !== 4'(model4)) begin
        errors++;
        $display("[TB] FAIL width4_random cycle %0d: q=%b expected=%b", i, q4, 4'(model4));
      end
    end
  endtask

  initial begin
    rst = 1'b0; shiftEn = 1'b0; shiftIn = 1'b0; extend = 1'b0;
    rst4 = 1'b0; shiftEn4 = 1'b0; shiftIn4 = 1'b0; extend4 = 1'b0;
    model8 = 0;
    model4 = 0;
    test_reset();
    test_shift_pattern();
    test_extend();
    test_saturate();
    test_reset_mid();
    test_random();
    test_width4();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
